// File: rtl/firefly_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : firefly_pkg                                               |
// | Purpose  : Shared definitions for the firefly flash regenerator:     |
// |            output-mode encodings and a saturating doubling helper.   |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package firefly_pkg;

  typedef enum logic [1:0] {
    MODE_MIRROR = 2'd0,
    MODE_INVERT = 2'd1,
    MODE_DOUBLE = 2'd2,
    MODE_HALF   = 2'd3
  } mode_e;

  // Shift left by one, clamping to max_val instead of wrapping.
  function automatic logic [31:0] sat_shl(input logic [31:0] v,
                                          input logic [31:0] max_val);
    logic [32:0] d;
    d = {v, 1'b0};
    if (d > {1'b0, max_val}) return max_val;
    return d[31:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/firefly_meter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : firefly_meter                                             |
// | Purpose  : Synchronises the asynchronous flash input, detects its    |
// |            rising edges and measures period / high time in clocks.   |
// | Ports    : clk, rst        - clock, synchronous active-high reset     |
// |            f0              - asynchronous flash input                |
// |            rise            - registered rising-edge strobe           |
// |            period/high_time/valid/overflow - latched measurement     |
// |            period_nxt/high_nxt/valid_nxt   - next-state values, so   |
// |              the generator can realign on the same edge they latch   |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module firefly_meter #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             f0,
  output logic             rise,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             valid,
  output logic             overflow,
  output logic [CNT_W-1:0] period_nxt,
  output logic [CNT_W-1:0] high_nxt,
  output logic             valid_nxt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [SYNC_STAGES-1:0] sync;
  logic                   lvl;    // edge register: synchronised level, aligned with rise
  logic                   armed;  // a phase-establishing rise has been seen
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       hcnt;
  logic                   sat;

  assign sat = (cnt == CNT_MAX);

  // Saturation wins over a coincident rise: the measurement is dropped.
  always_comb begin
    period_nxt = period;
    high_nxt   = high_time;
    valid_nxt  = valid;
    if (sat) begin
      valid_nxt = 1'b0;
    end else if (rise && armed) begin
      period_nxt = cnt;
      high_nxt   = hcnt;
      valid_nxt  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync      <= '0;
      lvl       <= 1'b0;
      rise      <= 1'b0;
      armed     <= 1'b0;
      cnt       <= '0;
      hcnt      <= '0;
      period    <= '0;
      high_time <= '0;
      valid     <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      sync      <= {sync[SYNC_STAGES-2:0], f0};
      lvl       <= sync[SYNC_STAGES-1];
      rise      <= sync[SYNC_STAGES-1] & ~lvl;
      period    <= period_nxt;
      high_time <= high_nxt;
      valid     <= valid_nxt;
      if (sat) overflow <= 1'b1;
      if (rise) begin
        // The rise cycle itself is high and the first cycle of the new period.
        cnt   <= CNT_ONE;
        hcnt  <= CNT_ONE;
        armed <= 1'b1;
      end else begin
        if (!sat) cnt <= cnt + CNT_ONE;
        if (lvl && (hcnt != CNT_MAX)) hcnt <= hcnt + CNT_ONE;
        if (sat) armed <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/firefly_echo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : firefly_echo                                              |
// | Purpose  : Regenerates a clean, phase-aligned flash from a measured  |
// |            slow input in mirror / invert / double / half mode.       |
// | Ports    : clk, rst  - clock, synchronous active-high reset           |
// |            f0        - asynchronous flash input                      |
// |            mode      - 0 mirror, 1 invert, 2 double, 3 half          |
// |            f1        - registered regenerated flash                  |
// |            period, high_time, valid, overflow - measurement readout  |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module firefly_echo
  import firefly_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             f0,
  input  logic [1:0]       mode,
  output logic             f1,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             valid,
  output logic             overflow
);

  localparam logic [31:0]    MAX32 = 32'((64'd1 << CNT_W) - 64'd1);
  localparam logic [CNT_W:0] G_ONE = {{CNT_W{1'b0}}, 1'b1};

  logic             rise;
  logic             valid_nxt;
  logic [CNT_W-1:0] period_nxt;
  logic [CNT_W-1:0] high_nxt;

  firefly_meter #(
    .CNT_W       (CNT_W),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_meter (
    .clk        (clk),
    .rst        (rst),
    .f0         (f0),
    .rise       (rise),
    .period     (period),
    .high_time  (high_time),
    .valid      (valid),
    .overflow   (overflow),
    .period_nxt (period_nxt),
    .high_nxt   (high_nxt),
    .valid_nxt  (valid_nxt)
  );

  logic [CNT_W-1:0] gcnt;
  logic [CNT_W-1:0] p_cur;
  logic [CNT_W-1:0] h_cur;
  logic [CNT_W-1:0] p_new;
  logic [CNT_W-1:0] h_new;
  logic [CNT_W-1:0] p_dbl;
  logic [CNT_W-1:0] h_dbl;
  logic [CNT_W:0]   gcnt_inc;
  logic             tog;
  logic             align;
  logic             wrap;

  assign p_dbl = CNT_W'(sat_shl(32'(period_nxt), MAX32));
  assign h_dbl = CNT_W'(sat_shl(32'(high_nxt), MAX32));

  // Targets are computed from the next-state measurement so a realign on
  // the latching edge already uses the fresh period.
  always_comb begin
    p_new = period_nxt;
    h_new = high_nxt;
    case (mode_e'(mode))
      MODE_MIRROR: begin
        p_new = period_nxt;
        h_new = high_nxt;
      end
      MODE_INVERT: begin
        p_new = period_nxt;
        h_new = period_nxt - high_nxt;
      end
      MODE_DOUBLE: begin
        p_new = {1'b0, period_nxt[CNT_W-1:1]};
        h_new = {1'b0, high_nxt[CNT_W-1:1]};
      end
      MODE_HALF: begin
        p_new = p_dbl;
        h_new = h_dbl;
      end
      default: ;
    endcase
  end

  // In half mode only every second rise realigns; tog marks the skipped one.
  assign align    = rise && ((mode_e'(mode) != MODE_HALF) || !tog);
  assign gcnt_inc = {1'b0, gcnt} + G_ONE;
  // ">=" also covers a zero-length target, which then wraps every cycle.
  assign wrap     = (gcnt_inc >= {1'b0, p_cur});

  always_ff @(posedge clk) begin
    if (rst) begin
      gcnt  <= '0;
      p_cur <= '0;
      h_cur <= '0;
      tog   <= 1'b0;
      f1    <= 1'b0;
    end else if (!valid_nxt) begin
      gcnt <= '0;
      tog  <= 1'b0;
      f1   <= 1'b0;
    end else begin
      if (rise) tog <= ~tog;
      if (align || wrap) begin
        gcnt  <= '0;
        p_cur <= p_new;
        h_cur <= h_new;
        f1    <= (h_new != '0);
      end else begin
        gcnt  <= gcnt_inc[CNT_W-1:0];
        f1    <= (gcnt_inc < {1'b0, h_cur});
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_firefly_echo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_firefly_echo                                           |
// | Purpose  : Self-checking bench for firefly_echo with a cycle-level   |
// |            reference model built from the recorded input edges.      |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_firefly_echo;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        f0 = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic        f1;
  logic [15:0] period;
  logic [15:0] high_time;
  logic        valid;
  logic        overflow;

  logic        rst8 = 1'b1;
  logic        f0_8 = 1'b0;
  logic [1:0]  mode8 = 2'd0;
  logic        f1_8;
  logic [7:0]  period8;
  logic [7:0]  high8;
  logic        valid8;
  logic        ovf8;

  int errs = 0;
  int chks = 0;
  int cyc  = 0;
  int rises[$];
  int falls[$];
  int mt[$];
  int mv[$];

  always #10 clk = ~clk;

  firefly_echo #(.CNT_W(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .f0(f0), .mode(mode), .f1(f1),
    .period(period), .high_time(high_time), .valid(valid), .overflow(overflow)
  );

  firefly_echo #(.CNT_W(8), .SYNC_STAGES(2)) dut8 (
    .clk(clk), .rst(rst8), .f0(f0_8), .mode(mode8), .f1(f1_8),
    .period(period8), .high_time(high8), .valid(valid8), .overflow(ovf8)
  );

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic set_f0(input logic v);
    if (v && !f0) rises.push_back(cyc);
    if (!v && f0) falls.push_back(cyc);
    f0 = v;
  endtask

  task automatic set_mode(input logic [1:0] v);
    mode = v;
    mt.push_back(cyc);
    mv.push_back(int'(v));
  endtask

  task automatic run(input logic v, input int n);
    set_f0(v);
    repeat (n) tick();
  endtask

  task automatic run8(input logic v, input int n);
    f0_8 = v;
    repeat (n) tick();
  endtask

  task automatic do_reset();
    f0 = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rises.delete();
    falls.delete();
    mt.delete();
    mv.delete();
  endtask

  // Mode seen by the DUT at clock edge e (inputs driven in cycle t act at edges > t).
  function automatic int mode_at(input int e);
    int v;
    v = mv[0];
    foreach (mv[i]) if (mt[i] < e) v = mv[i];
    return v;
  endfunction

  function automatic int pout(input int p, input int md);
    case (md)
      2:       return p / 2;
      3:       return (2 * p > 65535) ? 65535 : 2 * p;
      default: return p;
    endcase
  endfunction

  function automatic int hout(input int p, input int h, input int md);
    case (md)
      1:       return p - h;
      2:       return h / 2;
      3:       return (2 * h > 65535) ? 65535 : 2 * h;
      default: return h;
    endcase
  endfunction

  // Expected outputs after clock edge m. An input rise driven in cycle r
  // takes effect at edge r+4; the first rise only sets phase, the second
  // validates; half mode realigns on rises 1, 3, 5, ...
  task automatic model(input int m, output int ev, output int ep,
                       output int eh, output int ef);
    int k, pp, hh, anchor, t, po, ho, md;
    k = 0;
    foreach (rises[i]) if (rises[i] + 4 <= m) k = i + 1;
    ev = 0; ep = 0; eh = 0; ef = 0;
    if (k < 2) return;
    pp = rises[k-1] - rises[k-2];
    hh = falls[k-2] - rises[k-2];
    ev = 1; ep = pp; eh = hh;
    anchor = rises[1] + 4;
    for (int i = k - 1; i >= 1; i--) begin
      md = mode_at(rises[i] + 4);
      if (md != 3 || ((i - 1) % 2) == 0) begin
        anchor = rises[i] + 4;
        break;
      end
    end
    t = anchor;
    forever begin
      md = mode_at(t);
      po = pout(pp, md);
      if (po > 0 && t + po <= m) t += po;
      else break;
    end
    ho = hout(pp, hh, mode_at(t));
    ef = ((m - t) < ho) ? 1 : 0;
  endtask

  task automatic test_reset();
    do_reset();
    chks++; if (f1 !== 1'b0)        begin errs++; $display("FAIL reset_f1 got %b exp 0", f1); end
    chks++; if (valid !== 1'b0)     begin errs++; $display("FAIL reset_valid got %b exp 0", valid); end
    chks++; if (overflow !== 1'b0)  begin errs++; $display("FAIL reset_overflow got %b exp 0", overflow); end
    chks++; if (period !== 16'd0)   begin errs++; $display("FAIL reset_period got %0d exp 0", period); end
    chks++; if (high_time !== 16'd0) begin errs++; $display("FAIL reset_high_time got %0d exp 0", high_time); end
  endtask

  task automatic test_wave(input string nm, input int lo, input int hi, input int md,
                           input int nper, input int sw_at, input int sw_md);
    int ev, ep, eh, ef, n;
    do_reset();
    set_mode(2'(md));
    n = 0;
    for (int p = 0; p < nper; p++) begin
      for (int c = 0; c < lo + hi; c++) begin
        if (n == sw_at) set_mode(2'(sw_md));
        set_f0(c >= lo);
        tick();
        n++;
        model(cyc, ev, ep, eh, ef);
        chks++;
        if (f1 !== (ef != 0)) begin
          errs++; $display("FAIL %s f1 cycle %0d got %b exp %0d", nm, n, f1, ef);
        end
        chks++;
        if (valid !== (ev != 0)) begin
          errs++; $display("FAIL %s valid cycle %0d got %b exp %0d", nm, n, valid, ev);
        end
        if (ev != 0) begin
          chks++;
          if (period !== 16'(ep)) begin
            errs++; $display("FAIL %s period cycle %0d got %0d exp %0d", nm, n, period, ep);
          end
          chks++;
          if (high_time !== 16'(eh)) begin
            errs++; $display("FAIL %s high_time cycle %0d got %0d exp %0d", nm, n, high_time, eh);
          end
        end
      end
    end
    chks++;
    if (overflow !== 1'b0) begin
      errs++; $display("FAIL %s overflow got %b exp 0", nm, overflow);
    end
  endtask

  task automatic test_random();
    int lo, hi, md;
    for (int r = 0; r < 2; r++) begin
      lo = $urandom_range(600, 200);
      hi = $urandom_range(1200, 100);
      md = $urandom_range(3, 0);
      test_wave("random", lo, hi, md, 4, -1, 0);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_mode(2'd0);
    run(1'b0, 500); run(1'b1, 2000); run(1'b0, 500); run(1'b1, 1000);
    chks++; if (valid !== 1'b1)    begin errs++; $display("FAIL pre_rst_valid got %b exp 1", valid); end
    chks++; if (f1 !== 1'b1)       begin errs++; $display("FAIL pre_rst_f1 got %b exp 1", f1); end
    chks++; if (period !== 16'd2500) begin errs++; $display("FAIL pre_rst_period got %0d exp 2500", period); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chks++; if (f1 !== 1'b0)        begin errs++; $display("FAIL mid_rst_f1 got %b exp 0", f1); end
    chks++; if (valid !== 1'b0)     begin errs++; $display("FAIL mid_rst_valid got %b exp 0", valid); end
    chks++; if (period !== 16'd0)   begin errs++; $display("FAIL mid_rst_period got %0d exp 0", period); end
    chks++; if (high_time !== 16'd0) begin errs++; $display("FAIL mid_rst_high_time got %0d exp 0", high_time); end
    chks++; if (overflow !== 1'b0)  begin errs++; $display("FAIL mid_rst_overflow got %b exp 0", overflow); end
    run(1'b1, 1000); run(1'b0, 500); run(1'b1, 2000); run(1'b0, 500); run(1'b1, 10);
    chks++; if (valid !== 1'b1)     begin errs++; $display("FAIL post_rst_valid got %b exp 1", valid); end
    chks++; if (period !== 16'd2500) begin errs++; $display("FAIL post_rst_period got %0d exp 2500", period); end
    chks++; if (high_time !== 16'd2000) begin errs++; $display("FAIL post_rst_high_time got %0d exp 2000", high_time); end
  endtask

  task automatic test_overflow();
    rst8 = 1'b1;
    tick();
    rst8 = 1'b0;
    run8(1'b0, 20); run8(1'b1, 50); run8(1'b0, 100); run8(1'b1, 10);
    chks++; if (valid8 !== 1'b1)   begin errs++; $display("FAIL ovf_pre_valid got %b exp 1", valid8); end
    chks++; if (period8 !== 8'd150) begin errs++; $display("FAIL ovf_pre_period got %0d exp 150", period8); end
    chks++; if (high8 !== 8'd50)   begin errs++; $display("FAIL ovf_pre_high got %0d exp 50", high8); end
    chks++; if (ovf8 !== 1'b0)     begin errs++; $display("FAIL ovf_pre_overflow got %b exp 0", ovf8); end
    run8(1'b1, 40); run8(1'b0, 300);
    chks++; if (ovf8 !== 1'b1)     begin errs++; $display("FAIL ovf_overflow got %b exp 1", ovf8); end
    chks++; if (valid8 !== 1'b0)   begin errs++; $display("FAIL ovf_valid got %b exp 0", valid8); end
    chks++; if (f1_8 !== 1'b0)     begin errs++; $display("FAIL ovf_f1 got %b exp 0", f1_8); end
    run8(1'b1, 50);
    chks++; if (valid8 !== 1'b0)   begin errs++; $display("FAIL ovf_first_rise_valid got %b exp 0", valid8); end
    run8(1'b0, 100); run8(1'b1, 10);
    chks++; if (valid8 !== 1'b1)   begin errs++; $display("FAIL ovf_post_valid got %b exp 1", valid8); end
    chks++; if (period8 !== 8'd150) begin errs++; $display("FAIL ovf_post_period got %0d exp 150", period8); end
    chks++; if (high8 !== 8'd50)   begin errs++; $display("FAIL ovf_post_high got %0d exp 50", high8); end
    chks++; if (ovf8 !== 1'b1)     begin errs++; $display("FAIL ovf_post_overflow got %b exp 1", ovf8); end
  endtask

  initial begin
    test_reset();
    test_wave("mirror", 500, 2000, 0, 4, -1, 0);
    test_wave("invert", 500, 2000, 1, 3, -1, 0);
    test_wave("double", 500, 2000, 2, 3, -1, 0);
    test_wave("half",   750, 1750, 3, 4, -1, 0);
    test_wave("switch", 500, 2000, 0, 4, 2 * 2500 + 500 + 1000, 2);
    test_random();
    test_reset_mid();
    test_overflow();
    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end

endmodule
`default_nettype wire
